// File: rtl/puf_eval_controller.sv
// Sequencing controller for the 8-bit parallel PUF array: runs EVAL_COUNT evaluations
// per request, majority-votes each response bit and reports stability and timeout.
module puf_eval_controller #(
    parameter int EVAL_COUNT     = 5,
    parameter int RESET_CYCLES   = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clock,
    input  logic        computer_reset,
    // Both ports use valid/ready: a transfer happens on a rising clock edge where
    // valid && ready; the producer holds valid and payload stable until then.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_challenge,
    input  logic [31:0] req_enable,
    output logic [7:0]  puf_challenge,
    output logic [31:0] puf_enable,
    output logic        puf_reset,
    input  logic [7:0]  puf_out,
    input  logic        puf_all_done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_response,
    output logic [7:0]  rsp_unstable,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_ARM       = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CAPTURE   = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

    localparam int TMAX_A = (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES;
    localparam int TMAX   = (TMAX_A > SETTLE_CYCLES) ? TMAX_A : SETTLE_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [TW-1:0] RESET_LAST   = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    EVAL_LAST    = 4'(EVAL_COUNT - 1);
    localparam logic [3:0]    EVAL_N       = 4'(EVAL_COUNT);
    localparam logic [3:0]    EVAL_HALF    = 4'(EVAL_COUNT / 2);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q;
    logic [3:0]      eval_idx_q;
    logic [7:0][3:0] vote_q, vote_d;
    logic [7:0]      resp_d, unstable_d;
    logic [31:0]     en_mask_q;
    logic            done_meta, done_s;
    logic [7:0]      out_meta, out_s;
    logic            accept, timed_out;

    assign state_dbg = state_q;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept  = 1'b1;
                    state_d = ST_RESET;
                end
            end
            ST_RESET: begin
                if (timer_q == RESET_LAST) state_d = ST_ARM;
            end
            ST_ARM: begin
                // A done still high from the previous evaluation must fall before we wait on it.
                if (timer_q == TIMEOUT_LAST) begin
                    timed_out = 1'b1;
                    state_d   = ST_RESP;
                end else if (timer_q >= SETTLE_LAST && !done_s) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (done_s) begin
                    state_d = ST_CAPTURE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    timed_out = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_CAPTURE: begin
                state_d = (eval_idx_q == EVAL_LAST) ? ST_RESP : ST_RESET;
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Votes including the current capture, so the response can be registered on RESP entry.
    always_comb begin
        vote_d     = vote_q;
        resp_d     = '0;
        unstable_d = '0;
        for (int i = 0; i < 8; i++) begin
            vote_d[i]     = vote_q[i] + {3'b000, out_s[i]};
            resp_d[i]     = (vote_d[i] > EVAL_HALF);
            unstable_d[i] = (vote_d[i] != 4'd0) && (vote_d[i] != EVAL_N);
        end
    end

    always_ff @(posedge clock) begin
        if (computer_reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            eval_idx_q    <= '0;
            vote_q        <= '0;
            en_mask_q     <= '0;
            done_meta     <= 1'b0;
            done_s        <= 1'b0;
            out_meta      <= '0;
            out_s         <= '0;
            req_ready     <= 1'b0;
            busy          <= 1'b0;
            puf_challenge <= '0;
            puf_enable    <= '0;
            puf_reset     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_response  <= '0;
            rsp_unstable  <= '0;
            rsp_timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_meta <= puf_all_done;
            done_s    <= done_meta;
            out_meta  <= puf_out;
            out_s     <= out_meta;

            // One timer serves the reset hold, the settle delay and the timeout.
            if (state_d != state_q && (state_d == ST_RESET || state_d == ST_ARM)) begin
                timer_q <= '0;
            end else if (state_q inside {ST_RESET, ST_ARM, ST_WAIT_DONE}) begin
                timer_q <= timer_q + TW'(1);
            end

            if (accept) begin
                puf_challenge <= req_challenge;
                en_mask_q     <= req_enable;
                vote_q        <= '0;
                eval_idx_q    <= '0;
            end else if (state_q == ST_CAPTURE) begin
                vote_q     <= vote_d;
                eval_idx_q <= eval_idx_q + 4'd1;
            end

            req_ready  <= (state_d == ST_IDLE);
            busy       <= (state_d != ST_IDLE);
            rsp_valid  <= (state_d == ST_RESP);
            puf_reset  <= (state_d inside {ST_IDLE, ST_RESET, ST_RESP});
            puf_enable <= (state_d inside {ST_ARM, ST_WAIT_DONE, ST_CAPTURE}) ? en_mask_q : 32'd0;

            if (state_q == ST_CAPTURE && state_d == ST_RESP) begin
                rsp_response <= resp_d;
                rsp_unstable <= unstable_d;
                rsp_timeout  <= 1'b0;
            end else if (timed_out) begin
                rsp_response <= '0;
                rsp_unstable <= '0;
                rsp_timeout  <= 1'b1;
            end else if (state_q == ST_RESP && state_d == ST_IDLE) begin
                rsp_response <= '0;
                rsp_unstable <= '0;
                rsp_timeout  <= 1'b0;
            end
        end
    end

endmodule
